// File: rtl/bp_stall_pkg.sv
// Shared types and address offsets for the stall-cycle counter bank.
// Read addresses past the per-reason counters are offsets from channels_p.
package bp_stall_pkg;

  typedef enum logic [4:0] {
    stall_icache_miss_e   = 5'd0,
    stall_itlb_miss_e     = 5'd1,
    stall_branch_mispr_e  = 5'd2,
    stall_dcache_miss_e   = 5'd3,
    stall_dtlb_miss_e     = 5'd4,
    stall_long_latency_e  = 5'd5,
    stall_fence_e         = 5'd6,
    stall_exception_e     = 5'd7
  } bp_stall_reason_e;

  localparam int bp_stall_total_offset_lp = 0;
  localparam int bp_stall_mask_offset_lp  = 1;

  typedef enum logic {
    rd_idle_s = 1'b0,
    rd_full_s = 1'b1
  } bp_stall_rd_state_e;

endpackage

// File: rtl/bp_stall_counter_cell.sv
// One live counter with sticky overflow flag plus its snapshot shadow.
// Live state updates the cycle after inc_i; the shadow captures the pre-increment value.
module bp_stall_counter_cell #(
  parameter int width_p    = 32,
  parameter bit saturate_p = 1'b1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               inc_i,
  input  logic               load_i,
  output logic [width_p-1:0] shadow_cnt_o,
  output logic               shadow_ovf_o
);

  logic [width_p-1:0] cnt_d, cnt_q;
  logic [width_p-1:0] shadow_cnt_d, shadow_cnt_q;
  logic               ovf_d, ovf_q;
  logic               shadow_ovf_d, shadow_ovf_q;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clear_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (inc_i) begin
      if (&cnt_q) begin
        // Flag on the first increment attempted at max, whether it sticks or wraps.
        ovf_d = 1'b1;
        cnt_d = saturate_p ? cnt_q : '0;
      end else begin
        cnt_d = cnt_q + width_p'(1);
      end
    end
    shadow_cnt_d = load_i ? cnt_q : shadow_cnt_q;
    shadow_ovf_d = load_i ? ovf_q : shadow_ovf_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      shadow_cnt_q <= '0;
      shadow_ovf_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      shadow_cnt_q <= shadow_cnt_d;
      shadow_ovf_q <= shadow_ovf_d;
    end
  end

  assign shadow_cnt_o = shadow_cnt_q;
  assign shadow_ovf_o = shadow_ovf_q;

endmodule

// File: rtl/bp_stall_counter_bank.sv
// Per-reason stall-cycle counters with atomic snapshot, read through a valid/yumi port.
// Read data is registered one cycle after acceptance; ready drops while data is held unconsumed.
module bp_stall_counter_bank
  import bp_stall_pkg::*;
#(
  parameter int  channels_p      = 32,
  parameter int  width_p         = 32,
  parameter bit  saturate_p      = 1'b1,
  localparam int reason_width_lp = $clog2(channels_p),
  localparam int addr_width_lp   = $clog2(channels_p + 2)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       freeze_i,
  input  logic                       instret_i,
  input  logic [reason_width_lp-1:0] reason_i,
  input  logic                       snapshot_i,
  input  logic                       rd_v_i,
  input  logic [addr_width_lp-1:0]   rd_addr_i,
  output logic                       rd_ready_o,
  output logic                       rd_data_v_o,
  output logic [width_p-1:0]         rd_data_o,
  input  logic                       rd_yumi_i
);

  localparam int total_addr_lp = channels_p + bp_stall_total_offset_lp;
  localparam int mask_addr_lp  = channels_p + bp_stall_mask_offset_lp;

  // The overflow mask, including the total's flag, must fit in one read word.
  if (channels_p + 1 > width_p) begin : g_bad_width
    $error("bp_stall_counter_bank: channels_p+1 exceeds width_p");
  end

  logic                 stall;
  logic [channels_p:0]  inc_vec;
  logic [width_p-1:0]   shadow_cnt [channels_p+1];
  logic [channels_p:0]  shadow_ovf;
  logic [width_p-1:0]   rd_mux_dat;

  assign stall = ~instret_i & ~freeze_i;

  // Out-of-range reason codes match no channel and only reach the total.
  always_comb begin
    inc_vec = '0;
    for (int i = 0; i < channels_p; i++) begin
      inc_vec[i] = stall && (reason_i == reason_width_lp'(i));
    end
    inc_vec[channels_p] = stall;
  end

  for (genvar g = 0; g <= channels_p; g++) begin : g_cell
    bp_stall_counter_cell #(
      .width_p   (width_p),
      .saturate_p(saturate_p)
    ) u_cell (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .clear_i     (freeze_i),
      .inc_i       (inc_vec[g]),
      .load_i      (snapshot_i),
      .shadow_cnt_o(shadow_cnt[g]),
      .shadow_ovf_o(shadow_ovf[g])
    );
  end

  always_comb begin
    rd_mux_dat = '0;
    for (int i = 0; i < channels_p; i++) begin
      if (rd_addr_i == addr_width_lp'(i)) rd_mux_dat = shadow_cnt[i];
    end
    if (rd_addr_i == addr_width_lp'(total_addr_lp)) rd_mux_dat = shadow_cnt[channels_p];
    if (rd_addr_i == addr_width_lp'(mask_addr_lp))  rd_mux_dat = width_p'(shadow_ovf);
  end

  bp_stall_rd_state_e rd_state_q;
  logic               rd_data_v_q;
  logic [width_p-1:0] rd_data_q;

  // Data only loads on acceptance, so snapshots never disturb a held response.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_state_q  <= rd_idle_s;
      rd_data_v_q <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      case (rd_state_q)
        rd_idle_s: begin
          if (rd_v_i) begin
            rd_state_q  <= rd_full_s;
            rd_data_v_q <= 1'b1;
            rd_data_q   <= rd_mux_dat;
          end
        end
        rd_full_s: begin
          if (rd_yumi_i) begin
            if (rd_v_i) begin
              rd_data_q <= rd_mux_dat;
            end else begin
              rd_state_q  <= rd_idle_s;
              rd_data_v_q <= 1'b0;
            end
          end
        end
        default: begin
          rd_state_q  <= rd_idle_s;
          rd_data_v_q <= 1'b0;
        end
      endcase
    end
  end

  assign rd_ready_o  = (rd_state_q == rd_idle_s) | rd_yumi_i;
  assign rd_data_v_o = rd_data_v_q;
  assign rd_data_o   = rd_data_q;

endmodule

// File: tb/tb_bp_stall_counter_bank.sv
// Bench for bp_stall_counter_bank: three instances (wide saturating, narrow saturating, narrow wrapping)
// driven in lockstep and compared each cycle against an unbounded-count reference model.
module tb_bp_stall_counter_bank;
  import bp_stall_pkg::*;

  int  ch_m  [3] = '{10, 3, 3};
  int  wd_m  [3] = '{32, 4, 4};
  bit  sat_m [3] = '{1'b1, 1'b1, 1'b0};

  logic       clk = 1'b0;
  logic       reset = 1'b1, freeze = 1'b0, instret = 1'b1, snap = 1'b0, rd_v = 1'b0, yumi = 1'b0;
  logic [3:0] reason = '0, addr = '0;
  logic [1:0] reason_bc;
  logic [2:0] addr_bc;
  logic       rdy_a, rdy_b, rdy_c, dv_a, dv_b, dv_c;
  logic [31:0] dat_a;
  logic [3:0]  dat_b, dat_c;

  assign reason_bc = reason[1:0];
  assign addr_bc   = addr[2:0];

  always #5 clk = ~clk;

  bp_stall_counter_bank #(.channels_p(10), .width_p(32), .saturate_p(1'b1)) u_a (
    .clk_i(clk), .reset_i(reset), .freeze_i(freeze), .instret_i(instret), .reason_i(reason),
    .snapshot_i(snap), .rd_v_i(rd_v), .rd_addr_i(addr), .rd_ready_o(rdy_a),
    .rd_data_v_o(dv_a), .rd_data_o(dat_a), .rd_yumi_i(yumi));
  bp_stall_counter_bank #(.channels_p(3), .width_p(4), .saturate_p(1'b1)) u_b (
    .clk_i(clk), .reset_i(reset), .freeze_i(freeze), .instret_i(instret), .reason_i(reason_bc),
    .snapshot_i(snap), .rd_v_i(rd_v), .rd_addr_i(addr_bc), .rd_ready_o(rdy_b),
    .rd_data_v_o(dv_b), .rd_data_o(dat_b), .rd_yumi_i(yumi));
  bp_stall_counter_bank #(.channels_p(3), .width_p(4), .saturate_p(1'b0)) u_c (
    .clk_i(clk), .reset_i(reset), .freeze_i(freeze), .instret_i(instret), .reason_i(reason_bc),
    .snapshot_i(snap), .rd_v_i(rd_v), .rd_addr_i(addr_bc), .rd_ready_o(rdy_c),
    .rd_data_v_o(dv_c), .rd_data_o(dat_c), .rd_yumi_i(yumi));

  // Reference: true (unbounded) event counts; index ch_m[m] holds the total.
  longint live [3][0:10];
  longint shad [3][0:10];
  bit     ev   [3];
  longint ed   [3];
  longint rres [3];
  int     checks = 0, failures = 0;

  function automatic longint maxv(int m);
    return (longint'(1) << wd_m[m]) - 1;
  endfunction

  function automatic longint shown(int m, longint t);
    if (sat_m[m]) return (t > maxv(m)) ? maxv(m) : t;
    return t & maxv(m);
  endfunction

  function automatic int ra(int m);
    return (m == 0) ? int'(reason) : int'(reason_bc);
  endfunction

  function automatic int aa(int m);
    return (m == 0) ? int'(addr) : int'(addr_bc);
  endfunction

  function automatic longint exp_read(int m, int a);
    longint r;
    r = 0;
    if (a <= ch_m[m]) return shown(m, shad[m][a]);
    if (a == ch_m[m] + 1) begin
      for (int i = 0; i <= ch_m[m]; i++)
        if (shad[m][i] > maxv(m)) r = r | (longint'(1) << i);
      return r;
    end
    return 0;
  endfunction

  function automatic longint act_dat(int m);
    if (m == 0) return longint'(dat_a);
    if (m == 1) return longint'(dat_b);
    return longint'(dat_c);
  endfunction

  function automatic logic act_v(int m);
    return (m == 0) ? dv_a : ((m == 1) ? dv_b : dv_c);
  endfunction

  function automatic logic act_rdy(int m);
    return (m == 0) ? rdy_a : ((m == 1) ? rdy_b : rdy_c);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one clock: update the model from the inputs the DUT is about to sample, then compare.
  task automatic tick();
    for (int m = 0; m < 3; m++) begin
      if (reset) begin
        ev[m] = 1'b0;
        ed[m] = 0;
      end else if ((!ev[m] || yumi) && rd_v) begin
        ev[m] = 1'b1;
        ed[m] = exp_read(m, aa(m));
      end else if (yumi) begin
        ev[m] = 1'b0;
      end
    end
    for (int m = 0; m < 3; m++) begin
      if (reset) begin
        for (int i = 0; i <= ch_m[m]; i++) begin live[m][i] = 0; shad[m][i] = 0; end
      end else begin
        if (snap) for (int i = 0; i <= ch_m[m]; i++) shad[m][i] = live[m][i];
        if (freeze) begin
          for (int i = 0; i <= ch_m[m]; i++) live[m][i] = 0;
        end else if (!instret) begin
          live[m][ch_m[m]]++;
          if (ra(m) < ch_m[m]) live[m][ra(m)]++;
        end
      end
    end
    @(posedge clk);
    #1;
    for (int m = 0; m < 3; m++) begin
      check($sformatf("ready[%0d]", m), 64'(act_rdy(m)), 64'(!ev[m] || yumi));
      check($sformatf("data_v[%0d]", m), 64'(act_v(m)), 64'(ev[m]));
      if (ev[m]) check($sformatf("data[%0d]", m), act_dat(m), ed[m]);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; freeze = 1'b0; instret = 1'b1; snap = 1'b0; rd_v = 1'b0; yumi = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic stall_n(input int n, input int r);
    instret = 1'b0; reason = 4'(r);
    repeat (n) tick();
    instret = 1'b1;
  endtask

  task automatic pulse_snap();
    snap = 1'b1; tick(); snap = 1'b0;
  endtask

  task automatic do_read(input int a);
    rd_v = 1'b1; addr = 4'(a); tick(); rd_v = 1'b0;
    for (int m = 0; m < 3; m++) rres[m] = act_dat(m);
    yumi = 1'b1; tick(); yumi = 1'b0;
  endtask

  typedef struct {
    logic        instret;
    logic [3:0]  reason;
    logic        snap;
    logic        rd_v;
    logic [3:0]  addr;
    logic        yumi;
    logic        exp_v;
    logic        chk_d;
    logic [31:0] exp_d;
  } vec_t;

  vec_t   tbl [12];
  longint got [$];
  int     ad  [5] = '{0, 1, 2, 2, 3};
  logic   ym  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  longint hd  [5] = '{1, 2, 2, 3, 4};

  initial begin
    for (int i = 0; i < 5; i++) tbl[i] = '{1'b0, 4'(stall_dcache_miss_e), 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 32'd0};
    tbl[5]  = '{1'b1, 4'd0, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 32'd0};
    tbl[6]  = '{1'b1, 4'd0, 1'b0, 1'b1, 4'd3,  1'b0, 1'b1, 1'b1, 32'd5};
    tbl[7]  = '{1'b1, 4'd0, 1'b0, 1'b1, 4'd10, 1'b1, 1'b1, 1'b1, 32'd5};
    tbl[8]  = '{1'b1, 4'd0, 1'b0, 1'b1, 4'd0,  1'b1, 1'b1, 1'b1, 32'd0};
    tbl[9]  = '{1'b1, 4'd0, 1'b0, 1'b1, 4'd11, 1'b1, 1'b1, 1'b1, 32'd0};
    tbl[10] = '{1'b1, 4'd0, 1'b0, 1'b1, 4'd15, 1'b1, 1'b1, 1'b1, 32'd0};
    tbl[11] = '{1'b1, 4'd0, 1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 32'd0};

    do_reset();
    check("reset_dat_a", 64'(dat_a), 64'd0);
    check("reset_dat_b", 64'(dat_b), 64'd0);
    check("reset_dat_c", 64'(dat_c), 64'd0);

    // Five reason-3 stalls, snapshot, then read counter, total, idle channel, mask, out-of-range.
    for (int i = 0; i < 12; i++) begin
      instret = tbl[i].instret; reason = tbl[i].reason; snap = tbl[i].snap;
      rd_v = tbl[i].rd_v; addr = tbl[i].addr; yumi = tbl[i].yumi;
      tick();
      check($sformatf("tbl%0d_v", i), 64'(dv_a), 64'(tbl[i].exp_v));
      if (tbl[i].chk_d) check($sformatf("tbl%0d_dat", i), 64'(dat_a), 64'(tbl[i].exp_d));
    end
    rd_v = 1'b0; yumi = 1'b0; snap = 1'b0; instret = 1'b1;

    // Alternating retire/stall on reason 0, snapshot mid-sequence on a stall cycle.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      instret = (i % 2 == 1); reason = 4'd0; snap = (i == 4);
      tick();
    end
    instret = 1'b1; snap = 1'b0;
    do_read(0);
    check("alt_snap_mid", rres[0], 2);
    pulse_snap();
    do_read(0);
    check("alt_final", rres[0], 5);

    // Saturate vs wrap on 4-bit counters.
    do_reset();
    stall_n(20, 1);
    pulse_snap();
    do_read(1);
    check("sat_wide_cnt1", rres[0], 20);
    check("sat_cnt1", rres[1], 15);
    check("wrap_cnt1", rres[2], 4);
    do_read(4);
    check("sat_mask_bit1", (rres[1] >> 1) & 1, 1);
    check("wrap_mask_bit1", (rres[2] >> 1) & 1, 1);
    check("sat_mask", rres[1], 10);
    check("wrap_mask", rres[2], 10);
    do_read(3);
    check("sat_total", rres[1], 15);
    check("wrap_total", rres[2], 4);
    do_read(11);
    check("wide_mask_clear", rres[0], 0);

    // Stale shadow, snapshot+freeze together, events dropped during freeze.
    do_reset();
    stall_n(4, 2);
    pulse_snap();
    stall_n(7, 2);
    do_read(2);
    check("stale_shadow", rres[0], 4);
    instret = 1'b0; reason = 4'd2; snap = 1'b1; freeze = 1'b1;
    tick();
    snap = 1'b0;
    repeat (3) tick();
    freeze = 1'b0; instret = 1'b1;
    do_read(2);
    check("snap_freeze_pre", rres[0], 11);
    pulse_snap();
    do_read(2);
    check("after_freeze_cnt", rres[0], 0);
    do_read(10);
    check("after_freeze_total", rres[0], 0);

    // Continuous reads with yumi 1,0,1,1: hold, ordering, no drop or duplicate.
    do_reset();
    for (int r = 0; r < 4; r++) stall_n(r + 1, r);
    pulse_snap();
    got.delete();
    rd_v = 1'b1;
    for (int i = 0; i < 5; i++) begin
      addr = 4'(ad[i]); yumi = ym[i];
      if (dv_a && yumi) got.push_back(longint'(dat_a));
      tick();
      check($sformatf("yumi_seq%0d", i), 64'(dat_a), 64'(hd[i]));
    end
    rd_v = 1'b0; yumi = 1'b1;
    if (dv_a && yumi) got.push_back(longint'(dat_a));
    tick();
    yumi = 1'b0;
    check("yumi_count", 64'(got.size()), 64'd4);
    for (int i = 0; i < got.size() && i < 4; i++) check($sformatf("yumi_order%0d", i), got[i], longint'(i + 1));

    // Out-of-range reason counts only in the total.
    do_reset();
    stall_n(3, 10);
    pulse_snap();
    do_read(10);
    check("oor_total", rres[0], 3);
    for (int c = 0; c < 10; c++) begin
      do_read(c);
      check($sformatf("oor_chan%0d", c), rres[0], 0);
    end
    do_read(15);
    check("addr_beyond_a", rres[0], 0);
    check("addr_beyond_b", rres[1], 0);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      reset   = ($urandom_range(0, 499) == 0);
      freeze  = ($urandom_range(0, 149) == 0);
      instret = ($urandom_range(0, 2) == 0);
      reason  = 4'($urandom_range(0, 15));
      snap    = ($urandom_range(0, 9) == 0);
      rd_v    = ($urandom_range(0, 1) == 1);
      addr    = 4'($urandom_range(0, 15));
      yumi    = ($urandom_range(0, 2) != 0);
      tick();
    end
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

endmodule

// File: doc/bp_stall_counter_bank.md
# bp_stall_counter_bank

Parametrised bank of per-reason stall-cycle counters with an atomic snapshot and a registered valid/yumi read port. It sits beside the core profiler. Each cycle the profiler reports whether an instruction retired and, if not, one encoded stall reason; the bank counts non-retiring cycles per reason. Host software reads a coherent snapshot of all counters through the read port, without a wide flat output bus.

## Interface
Parameters:
- channels_p, 32: number of stall reasons counted; reason codes are 0..channels_p-1.
- width_p, 32: counter and read-data width.
- saturate_p, 1: 1 = counters stick at 2^width_p-1; 0 = counters wrap to 0.
- reason_width_lp, `$clog2(channels_p)`: derived; the reason code width.
- addr_width_lp, `$clog2(channels_p+2)`: derived; the read address width.

Ports:
- clk_i  in  1  core clock; the only clock.
- reset_i  in  1  synchronous, active-high reset.
- freeze_i  in  1  synchronous clear of all live state while high.
- instret_i  in  1  an instruction retired this cycle.
- reason_i  in  reason_width_lp  stall reason; sampled only when instret_i=0.
- snapshot_i  in  1  copy all live counters and overflow flags into shadow registers.
- rd_v_i  in  1  read request valid.
- rd_addr_i  in  addr_width_lp  read address. 0..channels_p-1 selects a counter; channels_p selects the total stall count; channels_p+1 selects the overflow mask.
- rd_ready_o  out  1  read request accepted when rd_v_i & rd_ready_o.
- rd_data_v_o  out  1  read data valid.
- rd_data_o  out  width_p  read data.
- rd_yumi_i  in  1  consumer takes rd_data_o.

## Operation
- Stall cycle: instret_i=0 and not frozen. On a stall cycle, counter[reason_i] += 1 and total += 1.
- A reason_i value ≥ channels_p counts only in total.
- Saturating mode:
  - A counter at max stays at max.
  - Its overflow flag sets on the first increment attempted while at max.
- Wrapping mode:
  - A counter at max goes to 0.
  - Its overflow flag sets on that wrap.
- Overflow flags are sticky until reset or freeze. The total counter has its own flag at bit channels_p of the mask, so channels_p+1 ≤ width_p is required. This is checked by an elaboration assertion.
- Snapshot: every shadow register loads its live register's value at the snapshot_i edge. This is the pre-increment value, excluding that cycle's event. The load is atomic across all channels.
- Reads always return shadow values. Reading the overflow mask returns the shadow mask zero-extended.
- An address beyond channels_p+1 returns 0.
- Read FSM, states IDLE and FULL:
  - IDLE: rd_ready_o=1. An accepted request goes to FULL.
  - FULL: rd_data_v_o=1. rd_ready_o=rd_yumi_i.
  - yumi with no new request goes to IDLE.
  - yumi with a new request stays in FULL and loads the new data.
- rd_data_o is held stable while rd_data_v_o=1 and yumi is low. A snapshot during FULL does not alter the held data.

## Timing
- Reset values: all live and shadow counters 0; overflow flags 0; rd_data_v_o 0; rd_data_o 0; rd_ready_o 1.
- Live counters update 1 cycle after the event. A snapshot is visible to a read accepted in the cycle after snapshot_i.
- Read latency: data is valid on the cycle after acceptance. Back-to-back reads sustain 1 per cycle under continuous yumi.
- freeze_i clears live counters and live flags, not shadows. Events during freeze are dropped.
- freeze_i does not disturb the read FSM.
- reset_i mid-read drops the pending data.
- A simultaneous snapshot and freeze captures the pre-freeze values.
- Simultaneous reset and any other input: reset wins.

## Structure
- Shared package bp_stall_pkg:
  - the stall-reason enum that drives reason_i;
  - the localparam offsets for the total and overflow addresses.
- One sub-module, bp_stall_counter_cell: a width_p counter with saturate/wrap mode, a sticky overflow flag, clear, and a shadow register with load.
- The top level contains:
  - channels_p+1 cell instances;
  - the one-hot reason decode;
  - the read mux;
  - the 2-state read FSM.

## Test plan
- Reset, then 5 stalls with reason 3, then snapshot, then read addr 3 and addr channels_p: data 5 and 5. All other channels read 0.
- Alternating instret/stall for 10 cycles with reason 0: counter 0 = 5; a snapshot during the sequence returns the pre-edge count.
- width_p=4, saturate_p=1, 20 stalls on reason 1: counter = 15; overflow mask bit 1 = 1. With saturate_p=0: counter = 4, bit 1 = 1.
- Snapshot, 7 further stalls, then read without a new snapshot: the old value is returned. Assert freeze, then snapshot again: reads return 0.
- Continuous rd_v_i over addresses 0..3 with rd_yumi_i toggled 1,0,1,1: data held during yumi=0; 4 responses in order; no drop or duplicate.
- reason_i=channels_p (out of range) for 3 stalls: total = 3, all channels 0. Read addr channels_p+5: data 0.
